// File: rtl/bcd_updown_counter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_updown_counter_pkg: shared BCD digit constants and helpers   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package bcd_updown_counter_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_updown_counter_digit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_digit: one up/down BCD digit with screened parallel load      |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic               clk,
  input  logic               mr,
  input  logic               step,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               at_term
);

  logic [DIGIT_W-1:0] digit_q;

  // Non-BCD load values collapse to zero so the digit never leaves 0..9.
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      digit_q <= BCD_MIN;
    end else if (load) begin
      digit_q <= is_bcd(d) ? d : BCD_MIN;
    end else if (step) begin
      if (up) begin
        digit_q <= (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_q <= (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  assign q       = digit_q;
  assign at_term = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

endmodule
`default_nettype wire

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_updown_counter: cascadable multi-digit up/down BCD counter    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      mr,
  input  logic                      en,
  input  logic                      cin,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] d,
  output logic [DIGIT_W*DIGITS-1:0] q,
  output logic                      tc,
  output logic                      co,
  output logic                      err
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_term;
  logic [DIGITS-1:0] bad_digit;
  logic              err_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    // Ripple enable: a digit steps only when every lower digit is at terminal.
    if (i == 0) begin : g_first
      assign step[i] = en & cin;
    end else begin : g_next
      assign step[i] = step[i-1] & at_term[i-1];
    end

    assign bad_digit[i] = !is_bcd(d[DIGIT_W*i +: DIGIT_W]);

    bcd_digit u_digit (
      .clk     (clk),
      .mr      (mr),
      .step    (step[i]),
      .up      (up),
      .load    (load),
      .d       (d[DIGIT_W*i +: DIGIT_W]),
      .q       (q[DIGIT_W*i +: DIGIT_W]),
      .at_term (at_term[i])
    );
  end

  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      err_q <= 1'b0;
    end else if (load && (|bad_digit)) begin
      err_q <= 1'b1;
    end
  end

  assign tc  = &at_term;
  assign co  = tc & en & cin;
  assign err = err_q;

endmodule
`default_nettype wire

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter; next generation of the team's single-digit mod-10 down counter.
- Adds up/down direction, synchronous parallel load with invalid-digit screening, and cascade in/out for chaining instances.
- Used as a display/timer counter; several instances chain through cin/co.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); q width is 4*DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- mr  input  1  asynchronous active-low master reset.
- en  input  1  count enable.
- cin  input  1  cascade enable from the lower-order instance; tie to 1 when standalone.
- up  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load.
- d  input  4*DIGITS  load value, digit i in d[4i+3:4i].
- q  output  4*DIGITS  count value, BCD, digit 0 least significant.
- tc  output  1  terminal count: all digits 9 when up=1, all digits 0 when up=0.
- co  output  1  cascade out = tc & en & cin.
- err  output  1  sticky flag: a load contained a non-BCD digit.

Behaviour:
- Clocking and reset: one clock, clk; reset mr is asynchronous and active-low.
- Reset (mr=0, any time, including mid-count or mid-load): q=0, err=0. tc then follows up: tc=1 when up=0, 0 when up=1. co follows tc/en/cin.
- Priority on each rising clk edge with mr=1: load > count > hold.
- Load (load=1): captured regardless of en/cin.
  - Each digit of d with value 0..9 is loaded as-is.
  - Each digit with value 10..15 is loaded as 0, and err is set.
  - err stays set until mr=0; load does not clear it.
- Count (load=0, en=1, cin=1): digit i steps when all digits below i are at terminal value for the current direction (9 for up, 0 for down). Digit 0 steps every enabled cycle.
  - Up: 9 -> 0 with carry to the next digit.
  - Down: 0 -> 9 with borrow to the next digit.
  - Full wrap: up from all 9s goes to all 0s; down from all 0s goes to all 9s, in one cycle.
- Hold: load=0 and (en=0 or cin=0) leaves q unchanged.
- Direction change takes effect on the same edge; there is no pipeline.
- tc and co are combinational from q, up, en, cin, with zero latency. co is asserted in the cycle before the wrap edge, so a downstream instance steps on that same edge.
- Latency: q updates one clk edge after load or count is sampled.
- Internal digits are always valid BCD. No state outside 0..9 per digit is reachable after reset.

Decomposition:
- Shared package: BCD_MAX = 4'd9, BCD_MIN = 4'd0, DIGIT_W = 4, and a function is_bcd(digit).
- Sub-module bcd_digit, one per digit (generate loop):
  - Inputs: clk, mr, step, up, load, d.
  - Outputs: q[3:0], at_term.
  - Top level builds the ripple step chain (AND of lower at_term terms with en & cin), tc, co, and the sticky err.

Test Plan:
- Reset mid-count: DIGITS=2, count up to 37, pulse mr=0 between edges -> q=00 immediately, err=0, tc=1 while up=0.
- Up wrap and carry: load 98, up=1, en=cin=1 for 3 clocks -> q=99 (tc=1, co=1), then 00 (tc=0), then 01.
- Down borrow and wrap: load 10, up=0, 2 clocks -> q=09 then 08; load 00, 1 clock -> q=99. co=1 only while q=00.
- Load priority and invalid digits: en=0, load=1, d=0x3C -> q=30, err=1. Next load 0x45 -> q=45, err stays 1 until mr=0.
- Enable/cascade gating: q=55, en=1, cin toggling 1,0,1 with up=1 -> q=56, 56, 57. At q=59 with cin=0, co=0 and q holds.
- Direction flip at boundary: q=99, up=1 (tc=1), switch up=0 same cycle -> tc=0, next edge q=98.
